hazard_unit_mc: RTL and testbench

Parametrised successor to the pipeline hazard unit for the 5-stage CPU (IF/ID/EX/MEM/WB).
- Keeps EX-stage operand forwarding and generalises it in register-address width.
- Adds load-use and branch-in-ID stall detection, ID-stage branch-comparator forwarding and taken-branch flush.
- Adds a sequential stall FSM that freezes the front of the pipe for a multi-cycle multiply/divide unit (MDU).

---
 rtl/hazard_unit_mc_if.sv | 60 ++++++
 rtl/hazard_unit_mc.sv | 174 +++++++++++++++++
 tb/tb_hazard_unit_mc.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_mc_if.sv
// hazard_unit_mc_if
//   Bundles the pipeline-side signals seen by the hazard unit.
//   Pipeline -> hazard unit: ID/EX/MEM/WB register addresses and control bits,
//                            branch info and the EX-stage MDU start request.
//   Hazard unit -> pipeline: EX/ID forwarding selects, per-stage stall and
//                            flush controls, MDU busy/done status.
//   master: the pipeline datapath/control side.
//   slave : the hazard unit.
interface hazard_unit_mc_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs_id;
  logic [ADDR_W-1:0] rt_id;
  logic              branch_id;
  logic              pc_src_id;
  logic [ADDR_W-1:0] rs_ex;
  logic [ADDR_W-1:0] rt_ex;
  logic [ADDR_W-1:0] write_reg_ex;
  logic              cu_reg_write_ex;
  logic              cu_mem_to_reg_ex;
  logic              mdu_start_ex;
  logic [ADDR_W-1:0] write_reg_mem;
  logic              cu_reg_write_mem;
  logic              cu_mem_to_reg_mem;
  logic [ADDR_W-1:0] write_reg_wb;
  logic              cu_reg_write_wb;

  logic [1:0]        forward_a;
  logic [1:0]        forward_b;
  logic              forward_a_id;
  logic              forward_b_id;
  logic              stall_if;
  logic              stall_id;
  logic              stall_ex;
  logic              flush_id;
  logic              flush_ex;
  logic              flush_mem;
  logic              mdu_busy;
  logic              mdu_done;

  modport master (
    output rs_id, rt_id, branch_id, pc_src_id,
    output rs_ex, rt_ex, write_reg_ex, cu_reg_write_ex, cu_mem_to_reg_ex, mdu_start_ex,
    output write_reg_mem, cu_reg_write_mem, cu_mem_to_reg_mem,
    output write_reg_wb, cu_reg_write_wb,
    input  forward_a, forward_b, forward_a_id, forward_b_id,
    input  stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem,
    input  mdu_busy, mdu_done
  );

  modport slave (
    input  rs_id, rt_id, branch_id, pc_src_id,
    input  rs_ex, rt_ex, write_reg_ex, cu_reg_write_ex, cu_mem_to_reg_ex, mdu_start_ex,
    input  write_reg_mem, cu_reg_write_mem, cu_mem_to_reg_mem,
    input  write_reg_wb, cu_reg_write_wb,
    output forward_a, forward_b, forward_a_id, forward_b_id,
    output stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem,
    output mdu_busy, mdu_done
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc
//   Hazard unit for the 5-stage pipeline (IF/ID/EX/MEM/WB) with EX operand
//   forwarding, ID branch-comparator forwarding, load-use and branch-in-ID
//   stalls, taken-branch flush, and a stall FSM that freezes the front of the
//   pipe for the duration of a multi-cycle multiply/divide (MDU) op.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        hazard_unit_mc_if.slave (all pipeline inputs and hazard outputs)
//   stall_cnt  32-bit count of cycles with stall_if=1 (only when the macro
//              HAZARD_UNIT_MC_STALL_CNT_EN is defined)
//
// Parameters:
//   ADDR_W       register address width (register 0 is hard-wired zero)
//   MDU_LATENCY  total stall cycles per MDU op, 2..2**CNT_W
//   CNT_W        MDU down-counter width
module hazard_unit_mc #(
  parameter int ADDR_W      = 5,
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  hazard_unit_mc_if.slave  bus
`ifdef HAZARD_UNIT_MC_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  // The start cycle is one stall cycle and DONE is not, so BUSY lasts
  // MDU_LATENCY-1 cycles: counting down from MDU_LATENCY-2 to 0 inclusive.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LATENCY - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  mdu_state_t       state;
  mdu_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic mdu_stall;
  logic mdu_busy_raw;
  logic mdu_done_raw;
  logic lu_stall;
  logic br_stall;
  logic stall_any;

  // A reader matches a writer only for a non-zero register actually written.
  function automatic logic reg_match(input logic [ADDR_W-1:0] r,
                                     input logic [ADDR_W-1:0] w,
                                     input logic              we);
    return (r != '0) && (r == w) && we;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [ADDR_W-1:0] src,
                                         input logic [ADDR_W-1:0] w_mem,
                                         input logic              we_mem,
                                         input logic [ADDR_W-1:0] w_wb,
                                         input logic              we_wb);
    if (reg_match(src, w_mem, we_mem))
      return 2'b10;
    else if (reg_match(src, w_wb, we_wb))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Forwarding is pure steering and stays live through reset.
  assign bus.forward_a = fwd_sel(bus.rs_ex, bus.write_reg_mem, bus.cu_reg_write_mem,
                                 bus.write_reg_wb, bus.cu_reg_write_wb);
  assign bus.forward_b = fwd_sel(bus.rt_ex, bus.write_reg_mem, bus.cu_reg_write_mem,
                                 bus.write_reg_wb, bus.cu_reg_write_wb);

  // A load in MEM has no ALU result to hand the comparator yet.
  assign bus.forward_a_id = reg_match(bus.rs_id, bus.write_reg_mem, bus.cu_reg_write_mem)
                            & ~bus.cu_mem_to_reg_mem;
  assign bus.forward_b_id = reg_match(bus.rt_id, bus.write_reg_mem, bus.cu_reg_write_mem)
                            & ~bus.cu_mem_to_reg_mem;

  assign lu_stall = bus.cu_mem_to_reg_ex
                  & (reg_match(bus.rs_id, bus.write_reg_ex, bus.cu_reg_write_ex)
                   | reg_match(bus.rt_id, bus.write_reg_ex, bus.cu_reg_write_ex));

  // The ID comparator can't take an EX result at all, nor a MEM-stage load.
  assign br_stall = bus.branch_id
                  & (reg_match(bus.rs_id, bus.write_reg_ex, bus.cu_reg_write_ex)
                   | reg_match(bus.rt_id, bus.write_reg_ex, bus.cu_reg_write_ex)
                   | reg_match(bus.rs_id, bus.write_reg_mem,
                               bus.cu_reg_write_mem & bus.cu_mem_to_reg_mem)
                   | reg_match(bus.rt_id, bus.write_reg_mem,
                               bus.cu_reg_write_mem & bus.cu_mem_to_reg_mem));

  // MDU FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // MDU FSM: next state. mdu_start_ex is only looked at in IDLE, so the op
  // held in EX during the stall can advance out of DONE without retriggering.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.mdu_start_ex) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt == '0)
          state_nxt = DONE;
        else
          cnt_nxt = cnt - 1'b1;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // MDU FSM: outputs
  always_comb begin
    mdu_stall    = 1'b0;
    mdu_busy_raw = 1'b0;
    mdu_done_raw = 1'b0;
    unique case (state)
      IDLE:    mdu_stall    = bus.mdu_start_ex;
      BUSY: begin
        mdu_stall    = 1'b1;
        mdu_busy_raw = 1'b1;
      end
      DONE:    mdu_done_raw = 1'b1;
      default: mdu_stall    = 1'b0;
    endcase
  end

  assign stall_any = lu_stall | br_stall | mdu_stall;

  // While the MDU holds EX, its contents must survive, so no EX bubble then.
  assign bus.stall_if  = ~rst & stall_any;
  assign bus.stall_id  = ~rst & stall_any;
  assign bus.stall_ex  = ~rst & mdu_stall;
  assign bus.flush_ex  = ~rst & (lu_stall | br_stall) & ~mdu_stall;
  assign bus.flush_mem = ~rst & mdu_stall;
  assign bus.flush_id  = ~rst & bus.pc_src_id & bus.branch_id & ~stall_any;
  assign bus.mdu_busy  = ~rst & mdu_busy_raw;
  assign bus.mdu_done  = ~rst & mdu_done_raw;

`ifdef HAZARD_UNIT_MC_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (bus.stall_if)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
module tb_hazard_unit_mc;
  localparam int AW = 5;
  localparam int L  = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_unit_mc_if #(.ADDR_W(AW)) bus();

`ifdef HAZARD_UNIT_MC_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  hazard_unit_mc #(.ADDR_W(AW), .MDU_LATENCY(L), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef HAZARD_UNIT_MC_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: position of the current MDU op in its lifetime
  // (-1 = none; 0 = start cycle; 1..L-1 = busy; L = done cycle).
  int          ref_k   = -1;
  logic [31:0] ref_cnt = '0;

  function automatic bit m(input logic [AW-1:0] r, input logic [AW-1:0] w, input logic we);
    return (r != 0) && (r == w) && (we == 1'b1);
  endfunction

  function automatic int cur_k();
    if (ref_k < 0 && bus.mdu_start_ex) return 0;
    return ref_k;
  endfunction

  // {fa[1:0], fb[1:0], fa_id, fb_id, stall_if, stall_id, stall_ex,
  //  flush_id, flush_ex, flush_mem, busy, done}
  function automatic logic [13:0] model_outs();
    logic [1:0] fa, fb;
    bit lu, br, ms, st, busy, done, fid, fex;
    int k;
    fa = m(bus.rs_ex, bus.write_reg_mem, bus.cu_reg_write_mem) ? 2'b10 :
         m(bus.rs_ex, bus.write_reg_wb,  bus.cu_reg_write_wb)  ? 2'b01 : 2'b00;
    fb = m(bus.rt_ex, bus.write_reg_mem, bus.cu_reg_write_mem) ? 2'b10 :
         m(bus.rt_ex, bus.write_reg_wb,  bus.cu_reg_write_wb)  ? 2'b01 : 2'b00;
    lu = bus.cu_mem_to_reg_ex && (m(bus.rs_id, bus.write_reg_ex, bus.cu_reg_write_ex) ||
                                  m(bus.rt_id, bus.write_reg_ex, bus.cu_reg_write_ex));
    br = bus.branch_id && (m(bus.rs_id, bus.write_reg_ex, bus.cu_reg_write_ex) ||
                           m(bus.rt_id, bus.write_reg_ex, bus.cu_reg_write_ex) ||
                           (bus.cu_mem_to_reg_mem &&
                            (m(bus.rs_id, bus.write_reg_mem, bus.cu_reg_write_mem) ||
                             m(bus.rt_id, bus.write_reg_mem, bus.cu_reg_write_mem))));
    k    = cur_k();
    ms   = (k >= 0) && (k < L);
    busy = (k >= 1) && (k < L);
    done = (k == L);
    st   = lu || br || ms;
    fex  = (lu || br) && !ms;
    fid  = bus.pc_src_id && bus.branch_id && !st;
    if (rst) begin
      st = 0; ms = 0; busy = 0; done = 0; fid = 0; fex = 0;
    end
    return {fa, fb,
            logic'(m(bus.rs_id, bus.write_reg_mem, bus.cu_reg_write_mem) && !bus.cu_mem_to_reg_mem),
            logic'(m(bus.rt_id, bus.write_reg_mem, bus.cu_reg_write_mem) && !bus.cu_mem_to_reg_mem),
            logic'(st), logic'(st), logic'(ms), logic'(fid), logic'(fex), logic'(ms),
            logic'(busy), logic'(done)};
  endfunction

  function automatic logic [13:0] dut_outs();
    return {bus.forward_a, bus.forward_b, bus.forward_a_id, bus.forward_b_id,
            bus.stall_if, bus.stall_id, bus.stall_ex, bus.flush_id, bus.flush_ex,
            bus.flush_mem, bus.mdu_busy, bus.mdu_done};
  endfunction

  // Advance one clock, updating the model with the pre-edge inputs.
  task automatic tick();
    int k;
    logic [13:0] o;
    @(posedge clk);
    k = cur_k();
    o = model_outs();
    if (rst) begin
      ref_k   = -1;
      ref_cnt = '0;
    end else begin
      if (o[7]) ref_cnt = ref_cnt + 32'd1;
      ref_k = (k < 0 || k >= L) ? -1 : k + 1;
    end
    #1;
  endtask

  task automatic clear_inputs();
    bus.rs_id = '0; bus.rt_id = '0; bus.branch_id = 0; bus.pc_src_id = 0;
    bus.rs_ex = '0; bus.rt_ex = '0; bus.write_reg_ex = '0;
    bus.cu_reg_write_ex = 0; bus.cu_mem_to_reg_ex = 0; bus.mdu_start_ex = 0;
    bus.write_reg_mem = '0; bus.cu_reg_write_mem = 0; bus.cu_mem_to_reg_mem = 0;
    bus.write_reg_wb = '0; bus.cu_reg_write_wb = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick();
    // Stall-provoking inputs while in reset: outputs must still be 0.
    bus.mdu_start_ex = 1; bus.cu_mem_to_reg_ex = 1; bus.cu_reg_write_ex = 1;
    bus.write_reg_ex = 5; bus.rt_id = 5;
    #1;
    checks++;
    if ({bus.stall_if, bus.stall_id, bus.stall_ex, bus.flush_ex, bus.flush_mem,
         bus.mdu_busy, bus.mdu_done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_force: got %b expected 0000000",
               {bus.stall_if, bus.stall_id, bus.stall_ex, bus.flush_ex, bus.flush_mem,
                bus.mdu_busy, bus.mdu_done});
    end
    tick();
    clear_inputs();
    rst = 0;
    #1;
    checks++;
    if ({bus.stall_if, bus.mdu_busy, bus.mdu_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got %b expected 000", {bus.stall_if, bus.mdu_busy, bus.mdu_done});
    end
`ifdef HAZARD_UNIT_MC_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
    end
`endif
  endtask

  task automatic test_forwarding();
    clear_inputs();
    bus.rs_ex = 3; bus.write_reg_mem = 3; bus.cu_reg_write_mem = 1;
    bus.write_reg_wb = 3; bus.cu_reg_write_wb = 1;
    #1;
    checks++;
    if (bus.forward_a !== 2'b10) begin
      errors++;
      $display("FAIL fwd_mem_prio: got %b expected 10", bus.forward_a);
    end
    bus.rs_ex = 0;
    #1;
    checks++;
    if (bus.forward_a !== 2'b00) begin
      errors++;
      $display("FAIL fwd_r0: got %b expected 00", bus.forward_a);
    end
    bus.rt_ex = 4; bus.write_reg_wb = 4;
    #1;
    checks++;
    if (bus.forward_b !== 2'b01) begin
      errors++;
      $display("FAIL fwd_wb: got %b expected 01", bus.forward_b);
    end
    bus.cu_reg_write_wb = 0;
    #1;
    checks++;
    if (bus.forward_b !== 2'b00) begin
      errors++;
      $display("FAIL fwd_no_we: got %b expected 00", bus.forward_b);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    bus.cu_mem_to_reg_ex = 1; bus.cu_reg_write_ex = 1; bus.write_reg_ex = 5; bus.rt_id = 5;
    #1;
    checks++;
    if ({bus.stall_if, bus.stall_id, bus.flush_ex, bus.stall_ex, bus.flush_mem} !== 5'b11100) begin
      errors++;
      $display("FAIL load_use: got %b expected 11100",
               {bus.stall_if, bus.stall_id, bus.flush_ex, bus.stall_ex, bus.flush_mem});
    end
    bus.write_reg_ex = 0; bus.rt_id = 0;
    #1;
    checks++;
    if ({bus.stall_if, bus.flush_ex} !== 2'b00) begin
      errors++;
      $display("FAIL load_use_r0: got %b expected 00", {bus.stall_if, bus.flush_ex});
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_branch();
    clear_inputs();
    bus.branch_id = 1; bus.pc_src_id = 1; bus.rs_id = 7;
    bus.write_reg_ex = 7; bus.cu_reg_write_ex = 1;
    #1;
    checks++;
    if ({bus.stall_id, bus.flush_id, bus.flush_ex} !== 3'b101) begin
      errors++;
      $display("FAIL branch_ex_dep: got %b expected 101", {bus.stall_id, bus.flush_id, bus.flush_ex});
    end
    tick();
    // Producer has moved to MEM and is an ALU op.
    bus.write_reg_ex = 0; bus.cu_reg_write_ex = 0;
    bus.write_reg_mem = 7; bus.cu_reg_write_mem = 1; bus.cu_mem_to_reg_mem = 0;
    #1;
    checks++;
    if ({bus.forward_a_id, bus.stall_id, bus.flush_id} !== 3'b101) begin
      errors++;
      $display("FAIL branch_mem_fwd: got %b expected 101",
               {bus.forward_a_id, bus.stall_id, bus.flush_id});
    end
    bus.cu_mem_to_reg_mem = 1;
    #1;
    checks++;
    if ({bus.forward_a_id, bus.stall_id, bus.flush_id} !== 3'b010) begin
      errors++;
      $display("FAIL branch_mem_load: got %b expected 010",
               {bus.forward_a_id, bus.stall_id, bus.flush_id});
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_mdu();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
    #1;
`ifdef HAZARD_UNIT_MC_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL mdu_cnt_start: got %0d expected 0", stall_cnt);
    end
`endif
    bus.mdu_start_ex = 1;
    for (int c = 0; c <= 5; c++) begin
      if (c == 1) begin
        // Concurrent load-use: EX is held, so no bubble into EX.
        bus.cu_mem_to_reg_ex = 1; bus.cu_reg_write_ex = 1; bus.write_reg_ex = 9; bus.rs_id = 9;
      end else begin
        bus.cu_mem_to_reg_ex = 0; bus.cu_reg_write_ex = 0; bus.write_reg_ex = 0; bus.rs_id = 0;
      end
      if (c == 5) bus.mdu_start_ex = 0;
      #1;
      checks++;
      if ({bus.stall_if, bus.stall_ex, bus.flush_mem, bus.mdu_busy, bus.mdu_done, bus.flush_ex} !==
          {(c <= 3) ? 3'b111 : 3'b000, logic'(c >= 1 && c <= 3), logic'(c == 4), 1'b0}) begin
        errors++;
        $display("FAIL mdu_cycle%0d: got %b expected %b", c,
                 {bus.stall_if, bus.stall_ex, bus.flush_mem, bus.mdu_busy, bus.mdu_done, bus.flush_ex},
                 {(c <= 3) ? 3'b111 : 3'b000, logic'(c >= 1 && c <= 3), logic'(c == 4), 1'b0});
      end
      if (c == 4) bus.mdu_start_ex = 0;
      tick();
    end
`ifdef HAZARD_UNIT_MC_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd4) begin
      errors++;
      $display("FAIL mdu_cnt_op: got %0d expected 4", stall_cnt);
    end
`endif
  endtask

  task automatic test_mdu_reset();
    clear_inputs();
    bus.mdu_start_ex = 1;
    #1;
    tick();                // now 1st BUSY cycle
    bus.mdu_start_ex = 0;
    tick();                // now 2nd BUSY cycle
    checks++;
    if (bus.mdu_busy !== 1'b1) begin
      errors++;
      $display("FAIL mdu_rst_busy: got %b expected 1", bus.mdu_busy);
    end
    rst = 1;
    #1;
    checks++;
    if ({bus.stall_if, bus.stall_ex, bus.flush_mem, bus.mdu_busy, bus.mdu_done} !== 5'b0) begin
      errors++;
      $display("FAIL mdu_rst_force: got %b expected 00000",
               {bus.stall_if, bus.stall_ex, bus.flush_mem, bus.mdu_busy, bus.mdu_done});
    end
    tick();
    rst = 0;
    for (int c = 0; c < L + 1; c++) begin
      #1;
      checks++;
      if ({bus.stall_if, bus.mdu_busy, bus.mdu_done} !== 3'b000) begin
        errors++;
        $display("FAIL mdu_rst_abandon%0d: got %b expected 000", c,
                 {bus.stall_if, bus.mdu_busy, bus.mdu_done});
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [13:0] exp_o, got_o;
    for (int i = 0; i < 400; i++) begin
      bus.rs_id = AW'($urandom_range(0, 3)); bus.rt_id = AW'($urandom_range(0, 3));
      bus.branch_id = 1'($urandom_range(0, 1)); bus.pc_src_id = 1'($urandom_range(0, 1));
      bus.rs_ex = AW'($urandom_range(0, 3)); bus.rt_ex = AW'($urandom_range(0, 3));
      bus.write_reg_ex = AW'($urandom_range(0, 3));
      bus.cu_reg_write_ex = 1'($urandom_range(0, 1)); bus.cu_mem_to_reg_ex = 1'($urandom_range(0, 1));
      bus.mdu_start_ex = ($urandom_range(0, 5) == 0) || (i >= 200 && i < 215);
      bus.write_reg_mem = AW'($urandom_range(0, 3));
      bus.cu_reg_write_mem = 1'($urandom_range(0, 1)); bus.cu_mem_to_reg_mem = 1'($urandom_range(0, 1));
      bus.write_reg_wb = AW'($urandom_range(0, 3)); bus.cu_reg_write_wb = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 39) == 0);
      #1;
      exp_o = model_outs();
      got_o = dut_outs();
      checks++;
      if (got_o !== exp_o) begin
        errors++;
        $display("FAIL random_outs cycle %0d: got %b expected %b", i, got_o, exp_o);
      end
`ifdef HAZARD_UNIT_MC_STALL_CNT_EN
      checks++;
      if (stall_cnt !== ref_cnt) begin
        errors++;
        $display("FAIL random_stall_cnt cycle %0d: got %0d expected %0d", i, stall_cnt, ref_cnt);
      end
`endif
      tick();
    end
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    #2;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mdu();
    test_mdu_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
